// File: rtl/max7219_pkg.sv
`default_nettype none
// ============================================================================
// Module      : max7219_pkg
// Description : Shared constants and Code-B segment lookup for the MAX7219 link
// Revision    : 1.0
// ============================================================================
package max7219_pkg;

  localparam int FRAME_WIDTH = 16;

  localparam logic [3:0] ADDR_NOOP      = 4'h0;
  localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
  localparam logic [3:0] ADDR_DECODE    = 4'h9;
  localparam logic [3:0] ADDR_INTENSITY = 4'hA;
  localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
  localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
  localparam logic [3:0] ADDR_TEST      = 4'hF;

  // Result is {dp,a,b,c,d,e,f,g}; data bits [6:4] play no part.
  function automatic logic [7:0] code_b_seg(input logic [7:0] data);
    logic [6:0] seg;
    case (data[3:0])
      4'h0:    seg = 7'h7E;
      4'h1:    seg = 7'h30;
      4'h2:    seg = 7'h6D;
      4'h3:    seg = 7'h79;
      4'h4:    seg = 7'h33;
      4'h5:    seg = 7'h5B;
      4'h6:    seg = 7'h5F;
      4'h7:    seg = 7'h70;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h7B;
      4'hA:    seg = 7'h01;
      4'hB:    seg = 7'h4F;
      4'hC:    seg = 7'h37;
      4'hD:    seg = 7'h0E;
      4'hE:    seg = 7'h67;
      default: seg = 7'h00;
    endcase
    return {data[7], seg};
  endfunction

endpackage
`default_nettype wire

// File: rtl/max7219_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : max7219_receiver_if
// Description : Serial display link pins (sck / mosi / cs_n)
// Revision    : 1.0
// ============================================================================
interface max7219_receiver_if;
  logic sck;
  logic mosi;
  logic cs_n;

  modport master (output sck, output mosi, output cs_n);
  modport slave  (input  sck, input  mosi, input  cs_n);
endinterface
`default_nettype wire

// File: rtl/spi_rx_shifter.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_shifter
// Description : Pin synchronizers, edge detect, bit counter and frame shifter
// Revision    : 1.0
// ============================================================================
module spi_rx_shifter
  import max7219_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   res,
  max7219_receiver_if.slave      spi,
  output logic                   frame_done,
  output logic                   frame_ok,
  output logic [FRAME_WIDTH-1:0] frame_word
);

  localparam logic [4:0] c_cnt_full = 5'(FRAME_WIDTH);
  localparam logic [4:0] c_cnt_sat  = 5'(FRAME_WIDTH + 1);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic                   r_armed;
  logic                   r_active;
  logic [4:0]             r_bit_cnt;
  logic [FRAME_WIDTH-1:0] r_shift;

  logic w_sck_s, w_mosi_s, w_cs_s, w_vld;
  logic w_sck_rise, w_cs_fall, w_cs_rise;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_vld       <= '0;
    end else begin
      r_sck_sync[0]  <= spi.sck;
      r_mosi_sync[0] <= spi.mosi;
      r_cs_sync[0]   <= spi.cs_n;
      r_vld[0]       <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sck_sync[i]  <= r_sck_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
        r_cs_sync[i]   <= r_cs_sync[i-1];
        r_vld[i]       <= r_vld[i-1];
      end
    end
  end

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
  assign w_vld    = r_vld[SYNC_STAGES-1];

  // A falling cs_n only counts once a genuine high has been seen since reset,
  // so a frame already running when reset releases is never started.
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_cs_fall  = ~w_cs_s & r_cs_d & r_armed;
  assign w_cs_rise  = w_cs_s & ~r_cs_d;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sck_d   <= 1'b0;
      r_cs_d    <= 1'b1;
      r_armed   <= 1'b0;
      r_active  <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_sck_d <= w_sck_s;
      r_cs_d  <= w_cs_s;
      if (w_vld && w_cs_s) r_armed <= 1'b1;
      if (w_cs_fall)      r_active <= 1'b1;
      else if (w_cs_rise) r_active <= 1'b0;
      if (w_cs_fall) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (r_active && !w_cs_s && w_sck_rise) begin
        r_shift <= {r_shift[FRAME_WIDTH-2:0], w_mosi_s};
        if (r_bit_cnt != c_cnt_sat) r_bit_cnt <= r_bit_cnt + 5'd1;
      end
    end
  end

  assign frame_done = w_cs_rise & r_active & (r_bit_cnt != 5'd0);
  assign frame_ok   = (r_bit_cnt == c_cnt_full);
  assign frame_word = r_shift;

endmodule
`default_nettype wire

// File: rtl/max7219_receiver.sv
`default_nettype none
// ============================================================================
// Module      : max7219_receiver
// Description : MAX7219-style register file fed by the 16-bit serial link
// Revision    : 1.0
// ============================================================================
module max7219_receiver
  import max7219_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   res,
  max7219_receiver_if.slave      spi,
  input  logic [2:0]             rd_addr,
  output logic [7:0]             rd_raw,
  output logic [7:0]             rd_seg,
  output logic                   word_valid,
  output logic [FRAME_WIDTH-1:0] word_data,
  output logic                   frame_error,
  output logic [7:0]             decode_mode,
  output logic [3:0]             intensity,
  output logic [2:0]             scan_limit,
  output logic                   shutdown_n,
  output logic                   display_test
);

  logic                   w_frame_done;
  logic                   w_frame_ok;
  logic [FRAME_WIDTH-1:0] w_frame_word;
  logic                   w_write;
  logic [3:0]             w_addr;
  logic [7:0]             w_data;
  logic [7:0]             r_digit [NUM_DIGITS];

  spi_rx_shifter #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_shifter (
    .clk        (clk),
    .res        (res),
    .spi        (spi),
    .frame_done (w_frame_done),
    .frame_ok   (w_frame_ok),
    .frame_word (w_frame_word)
  );

  assign w_write = w_frame_done & w_frame_ok;
  assign w_addr  = w_frame_word[11:8];
  assign w_data  = w_frame_word[7:0];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      word_valid   <= 1'b0;
      frame_error  <= 1'b0;
      word_data    <= '0;
      decode_mode  <= '0;
      intensity    <= '0;
      scan_limit   <= '0;
      shutdown_n   <= 1'b0;
      display_test <= 1'b0;
    end else begin
      word_valid  <= w_write;
      frame_error <= w_frame_done & ~w_frame_ok;
      if (w_write) begin
        word_data <= w_frame_word;
        case (w_addr)
          ADDR_NOOP:      ;
          ADDR_DECODE:    decode_mode  <= w_data;
          ADDR_INTENSITY: intensity    <= w_data[3:0];
          ADDR_SCANLIMIT: scan_limit   <= w_data[2:0];
          ADDR_SHUTDOWN:  shutdown_n   <= w_data[0];
          ADDR_TEST:      display_test <= w_data[0];
          default:        ;
        endcase
      end
    end
  end

  // Digit addresses start at 0x1; NUM_DIGITS above 8 would collide with 0x9.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
    end else if (w_write) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (w_addr == ADDR_DIGIT0 + 4'(i)) r_digit[i] <= w_data;
    end
  end

  always_comb begin
    rd_raw = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (rd_addr == 3'(i)) rd_raw = r_digit[i];
    rd_seg = decode_mode[rd_addr] ? code_b_seg(rd_raw) : rd_raw;
  end

endmodule
`default_nettype wire

// File: tb/tb_max7219_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_max7219_receiver
// Description : Frame-level model checked against max7219_receiver every cycle
// Revision    : 1.0
// ============================================================================
module tb_max7219_receiver;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        res;
  logic [2:0]  rd_addr;
  logic [7:0]  rd_raw, rd_seg, decode_mode;
  logic        word_valid, frame_error, shutdown_n, display_test;
  logic [15:0] word_data;
  logic [3:0]  intensity;
  logic [2:0]  scan_limit;

  max7219_receiver_if spi_if ();

  max7219_receiver #(.NUM_DIGITS(8), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .res          (res),
    .spi          (spi_if),
    .rd_addr      (rd_addr),
    .rd_raw       (rd_raw),
    .rd_seg       (rd_seg),
    .word_valid   (word_valid),
    .word_data    (word_data),
    .frame_error  (frame_error),
    .decode_mode  (decode_mode),
    .intensity    (intensity),
    .scan_limit   (scan_limit),
    .shutdown_n   (shutdown_n),
    .display_test (display_test)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0, n_bad = 0, n_valid = 0, n_err = 0;

  typedef struct { int due; bit ok; logic [15:0] w; } ev_t;
  ev_t evq[$];

  // Expected display state, updated only when a frame is expected to land.
  logic [7:0] m_dig [8];
  logic [7:0] m_dec;
  logic [3:0] m_int;
  logic [2:0] m_scan;
  logic       m_shut, m_test;
  logic [15:0] m_word;
  logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h01, 7'h4F, 7'h37, 7'h0E, 7'h67, 7'h00};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 8'h00;
    m_dec = 0; m_int = 0; m_scan = 0; m_shut = 0; m_test = 0; m_word = 0;
    evq.delete();
  endtask

  function automatic void model_apply(input logic [15:0] w);
    int a;
    a = int'(w[11:8]);
    m_word = w;
    if (a >= 1 && a <= 8) m_dig[a-1] = w[7:0];
    else if (a == 9)  m_dec  = w[7:0];
    else if (a == 10) m_int  = w[3:0];
    else if (a == 11) m_scan = w[2:0];
    else if (a == 12) m_shut = w[0];
    else if (a == 15) m_test = w[0];
  endfunction

  bit         exp_v, exp_e;
  logic [7:0] exp_raw, exp_seg;
  ev_t        ev;

  always @(negedge clk) begin
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (evq.size() > 0 && evq[0].due == cyc) begin
      ev = evq.pop_front();
      exp_v = ev.ok;
      exp_e = !ev.ok;
      if (ev.ok) model_apply(ev.w);
    end
    exp_raw = m_dig[rd_addr];
    exp_seg = m_dec[rd_addr] ? {exp_raw[7], seg_tbl[exp_raw[3:0]]} : exp_raw;
    check("word_valid",   word_valid,   exp_v);
    check("frame_error",  frame_error,  exp_e);
    check("word_data",    word_data,    m_word);
    check("decode_mode",  decode_mode,  m_dec);
    check("intensity",    intensity,    m_int);
    check("scan_limit",   scan_limit,   m_scan);
    check("shutdown_n",   shutdown_n,   m_shut);
    check("display_test", display_test, m_test);
    check("rd_raw",       rd_raw,       exp_raw);
    check("rd_seg",       rd_seg,       exp_seg);
    if (word_valid)  n_valid++;
    if (frame_error) n_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_if.mosi = v[i];
      spi_if.sck  = 1'b0;
      tick(); tick();
      spi_if.sck  = 1'b1;
      tick(); tick();
    end
    spi_if.sck = 1'b0;
    tick(); tick();
  endtask

  task automatic close_frame(input int n, input logic [15:0] w, input bit counted);
    ev_t e;
    spi_if.cs_n = 1'b1;
    if (counted && n != 0) begin
      e.due = cyc + S + 1;
      e.ok  = (n == 16);
      e.w   = w;
      evq.push_back(e);
    end
    repeat (16) tick();
  endtask

  task automatic send_frame(input logic [31:0] v, input int n);
    spi_if.cs_n = 1'b0;
    tick(); tick();
    shift_bits(v, n);
    close_frame(n, v[15:0], 1'b1);
  endtask

  task automatic do_reset();
    res = 1'b1;
    model_reset();
    repeat (3) tick();
    res = 1'b0;
  endtask

  int v0, e0;

  initial begin
    res = 1'b1;
    rd_addr = 3'd0;
    spi_if.cs_n = 1'b1;
    spi_if.sck  = 1'b0;
    spi_if.mosi = 1'b0;
    model_reset();
    repeat (3) tick();
    check("lit_reset_word",  word_data,  16'h0000);
    check("lit_reset_shut",  shutdown_n, 1'b0);
    check("lit_reset_valid", word_valid, 1'b0);
    res = 1'b0;
    repeat (4) tick();

    send_frame(32'h0C01, 16);
    check("lit_shutdown_on", shutdown_n, 1'b1);
    check("lit_word_0c01",   word_data,  16'h0C01);
    check("lit_one_valid",   n_valid,    1);
    check("lit_no_error",    n_err,      0);

    send_frame(32'h09FF, 16);
    send_frame(32'h0105, 16);
    send_frame(32'h0283, 16);
    rd_addr = 3'd0; tick();
    check("lit_raw_d0", rd_raw, 8'h05);
    check("lit_seg_d0", rd_seg, 8'h5B);
    rd_addr = 3'd1; tick();
    check("lit_seg_d1", rd_seg, 8'hF9);

    send_frame(32'h0900, 16);
    rd_addr = 3'd2;
    send_frame(32'h0377, 16);
    check("lit_seg_raw_d2", rd_seg, 8'h77);

    e0 = n_err; v0 = n_valid;
    send_frame(32'h0ABC, 12);
    send_frame(32'h3FFFF, 18);
    check("lit_two_errors", n_err - e0,   2);
    check("lit_no_valid",   n_valid - v0, 0);
    check("lit_word_kept",  word_data,    16'h0377);

    // Reset mid-frame, release with cs_n still low, finish that frame.
    v0 = n_valid;
    spi_if.cs_n = 1'b0;
    tick(); tick();
    shift_bits(32'h0A, 8);
    do_reset();
    shift_bits(32'h0F, 8);
    close_frame(16, 16'h0A0F, 1'b0);
    send_frame(32'h0A07, 16);
    check("lit_intensity7",  intensity,    4'h7);
    check("lit_single_valid", n_valid - v0, 1);

    v0 = n_valid;
    for (int d = 1; d <= 6; d++) send_frame(32'h0100 * d + d, 16);
    check("lit_burst_valid", n_valid - v0, 6);
    rd_addr = 3'd5; tick();
    check("lit_burst_d5", rd_raw, 8'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
